// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the uart_rx_fifo receiver.
//   - parity_mode encodings (PAR_NONE / PAR_EVEN / PAR_ODD; 2'b11 behaves as none)
//   - receive FSM state encodings
//   - minimum symbol width and helpers for clamping / parity decoding
package uart_rx_fifo_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [15:0] MIN_SYMBOL_WIDTH = 16'd4;

  // Narrower symbols leave no room for a mid-bit sample point.
  function automatic logic [15:0] clamp_width(input logic [15:0] width);
    return (width < MIN_SYMBOL_WIDTH) ? MIN_SYMBOL_WIDTH : width;
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_edge.sv
// rx_sync_edge: two-flop synchroniser for the asynchronous rx pin plus a
// falling-edge detector on the synchronised line.
//   clk, rst_n : block clock, async active-low reset (all flops reset to 1 = idle line)
//   rx_i       : raw serial pin
//   line_o     : synchronised line level
//   fall_o     : high for one cycle after a synchronised 1->0 transition
module rx_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic line_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with runtime framing and an output FIFO.
//   clk, rst_n          : clock, async active-low reset
//   symbol_width [15:0] : clocks per bit (clamped to >= 4), latched at start edge
//   parity_mode  [1:0]  : none / even / odd (11 = none), latched at start edge
//   two_stop            : two stop bits, latched at start edge
//   rx                  : asynchronous serial input, idle high
//   m_valid/m_ready     : output handshake; m_data, m_parity_err, m_frame_err
//                         describe the FIFO head word
//   overrun             : one-cycle pulse when a finished word is dropped (FIFO full)
//   busy                : frame reception in progress
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          symbol_width,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic line, fall;

  rx_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx),
    .line_o(line),
    .fall_o(fall)
  );

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [2:0]           state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic [15:0]          width_q, width_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 two_q, two_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 push_q, push_d;
  logic                 tick_half, tick_bit;

  assign tick_half = (timer_q == (width_q >> 1) - 16'd1);
  assign tick_bit  = (timer_q == width_q - 16'd1);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 16'd1;
    width_d = width_q;
    pmode_d = pmode_q;
    two_d   = two_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (fall) begin
          state_d = ST_START;
          width_d = clamp_width(symbol_width);
          pmode_d = parity_mode;
          two_d   = two_stop;
          cnt_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (tick_half) begin
          timer_d = '0;
          // A line already back high at mid-start is a glitch, not a frame.
          state_d = line ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_bit) begin
          timer_d = '0;
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick_bit) begin
          timer_d = '0;
          perr_d  = (pmode_q == PAR_EVEN) ? (^shift_q ^ line) : ~(^shift_q ^ line);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick_bit) begin
          timer_d = '0;
          if (!line) ferr_d = 1'b1;
          if (two_q && (cnt_q == 4'd0)) begin
            cnt_d = 4'd1;
          end else begin
            state_d = ST_IDLE;
            push_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      width_q <= MIN_SYMBOL_WIDTH;
      pmode_q <= PAR_NONE;
      two_q   <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      width_q <= width_d;
      pmode_q <= pmode_d;
      two_q   <= two_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      push_q  <= push_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Output FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // The word registers still hold the finished frame during the push cycle.
  // ---------------------------------------------------------------------------
  logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_BITS+1:0] mem_q [FIFO_DEPTH];
  logic                 full, pop, wr_en;

  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign m_valid = (wr_ptr_q != rd_ptr_q);
  assign pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign wr_en   = push_q && (!full || pop);
  assign overrun = push_q && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the output gating below keeps the
  // visible head at zero whenever the FIFO is empty, including after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= {ferr_q, perr_q, shift_q};
  end

  assign {m_frame_err, m_parity_err, m_data} =
    m_valid ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with runtime-configurable framing, mid-bit sampling, per-word error flags and an output FIFO with valid/ready handshake. It replaces the fixed 8N1 receiver in the serial path: the pin side connects to the asynchronous `rx` line, and the core side connects to any valid/ready consumer.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of two ≥ 2.
- `clk` input, 1 bit: single clock for the whole block.
- `rst_n` input, 1 bit: asynchronous reset, active-low. Reset is asserted asynchronously and released synchronously to `clk`.
- `symbol_width` input, 16 bits: clock cycles per bit (clk_freq/baud_rate). Values below 4 are clamped to 4.
- `parity_mode` input, 2 bits: 00 none, 01 even, 10 odd, 11 reserved (treated as none).
- `two_stop` input, 1 bit: 1 selects two stop bits.
- `rx` input, 1 bit: serial line, asynchronous, idle high.
- `m_valid` output, 1 bit: FIFO head is valid.
- `m_ready` input, 1 bit: consumer accepts the head word.
- `m_data` output, DATA_BITS bits: received word, LSB first on the line.
- `m_parity_err` output, 1 bit: parity error for the head word.
- `m_frame_err` output, 1 bit: a stop bit was sampled low for the head word.
- `overrun` output, 1 bit: one-cycle pulse when a completed word is dropped because the FIFO is full.
- `busy` output, 1 bit: high from start-edge detection until the last stop sample.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1). A falling edge is a synchronised 1→0 transition.
- `parity_mode`, `two_stop` and `symbol_width` are latched when the start edge is detected. Changes during a frame have no effect on that frame.
- The state machine has five states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START on a falling edge. The bit timer is cleared.
- START: at timer = H−1, where H = `symbol_width`>>1, sample the line.
  - Line high: false start; return to IDLE with no push.
  - Line low: clear the timer and go to DATA.
- DATA: every W = `symbol_width` cycles, sample one bit into a shift register, LSB first. After DATA_BITS samples, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: take one sample. The error condition is XOR(data, sample) = 1 for even parity, or 0 for odd parity.
- STOP: take one or two samples. `frame_err` is set if any stop sample is 0.
  - After the last stop sample, push {frame_err, parity_err, data} and return to IDLE.
  - IDLE re-arms immediately. A new start edge is recognised only after the line has returned high, so a break (line held low) produces exactly one frame.
- FIFO write on push, read when `m_valid && m_ready`.
  - Push while full with no pop in the same cycle: drop the word and pulse `overrun`.
  - Push and pop in the same cycle while full: both succeed; no overrun.
  - Pop while empty: ignored.
- Reset mid-frame: the FIFO is emptied, the FSM goes to IDLE, and the partial frame is discarded.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_parity_err`=0, `m_frame_err`=0, `overrun`=0, `busy`=0. The synchroniser resets to 1 and the state to IDLE.
- Let cycle E be the cycle in which the synchronised falling edge is seen; E lags the pin by 2–3 cycles.
- Sample schedule, with p = 1 if parity is enabled, else 0:
  - Start sample at E+H.
  - Data bit i (0-based) at E+H+(i+1)·W.
  - Parity sample at E+H+(DATA_BITS+1)·W.
  - Stop sample(s) at E+H+(DATA_BITS+1+p)·W and, when `two_stop`=1, one W later.
- FIFO push occurs in the cycle after the last stop sample. `m_valid` rises on the following cycle; there is no fall-through.
- `overrun` pulses in the same cycle as the rejected push.
- `busy` falls in the cycle after the last stop sample.
- The FIFO output is stable while `m_valid && !m_ready`.

## Structure
- Shared include file holds:
  - localparams for `parity_mode` encodings (PAR_NONE, PAR_EVEN, PAR_ODD);
  - FSM state encodings;
  - the minimum symbol width (4).
- Sub-module `rx_sync_edge`: 2-flop synchroniser plus falling-edge detector, resetting to 1.
- The FIFO is inline (pointers of width log2(FIFO_DEPTH)+1) and is not a separate module.

## Test plan
- 8N1, W=16: send 0xA5 → after the stop sample, `m_valid`=1 and `m_data`=0xA5 with both error flags 0. Sample instants match the schedule above ±0 cycles.
- 8E1: send 0x3C with a correct parity bit, then 0x3C with the parity bit flipped → first word has `m_parity_err`=0, second has `m_parity_err`=1; both have `m_data`=0x3C.
- 7O2 (DATA_BITS=7): send 0x55 with the second stop bit driven 0 → `m_frame_err`=1 and `m_data`=0x55.
- Glitch: `rx` low for 3 cycles with W=16 → no push, `busy` returns to 0, next frame 0x12 is received correctly.
- Break: `rx` held low for 30 bit times → exactly one word 0x00 with `m_frame_err`=1. No further words arrive until `rx` goes high and then a new start bit is sent.
- FIFO_DEPTH=4, `m_ready`=0: send 5 frames → 4 stored, 1 `overrun` pulse on the 5th push. Then raise `m_ready` with a simultaneous push while full → no overrun, and the order is preserved. Assert `rst_n` mid-frame → all outputs return to their reset values.
